// File: rtl/led_pwm_pkg.sv
// LED PWM driver shared definitions.
// Register addresses, reset values and blink state encoding.
package led_pwm_pkg;

  localparam logic [1:0] ADDR_DUTY = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_HALF = 2'd2;
  localparam logic [1:0] ADDR_LED  = 2'd3;

  localparam logic [7:0]  DUTY_RST = 8'hFF;
  localparam logic [15:0] HALF_RST = 16'd100;
  localparam logic [7:0]  PWM_MAX  = 8'hFF;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_state_e;

  function automatic logic [31:0] zext10(input logic [9:0] v);
    return {22'b0, v};
  endfunction

endpackage

// File: rtl/led_pwm_driver_timebase.sv
// PWM timebase: prescaler, 8-bit period counter, duty shadow.
// Duty only takes effect at a period boundary.
module led_pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_duty,
  output logic       o_tick,
  output logic       o_boundary,
  output logic       o_pwm_on
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] r_pre;
  logic [7:0]  r_cnt;
  logic [7:0]  r_duty_act;

  assign o_tick     = (r_pre == PRE_LAST);
  assign o_boundary = o_tick & (r_cnt == PWM_MAX);
  assign o_pwm_on   = (r_duty_act == PWM_MAX) |
                      (r_cnt < r_duty_act);

  // prescaler, pwm counter and duty shadow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre      <= '0;
      r_cnt      <= '0;
      r_duty_act <= DUTY_RST;
    end else begin
      r_pre <= o_tick ? '0 : r_pre + 16'd1;
      if (o_tick)
        r_cnt <= r_cnt + 8'd1;
      if (o_boundary)
        r_duty_act <= i_duty;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM driver top: Avalon-MM regs, optional blink, LED output.
// Blink logic present only with LED_PWM_DRIVER_BLINK_EN defined.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  led_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [9:0]  led_out
);

  logic       w_wr;
  logic       w_tick;
  logic       w_boundary;
  logic       w_pwm_on;
  logic       w_blink_on;
  logic [9:0] w_mask;
  logic [15:0] w_hp;
  logic       w_unused;

  logic [7:0] r_duty;
  logic [9:0] r_led_q;
  logic [9:0] r_led_out;

  assign w_wr     = chipselect & ~write_n;
  assign led_out  = r_led_out;
  assign w_unused = ^{writedata[31:8], w_tick, w_boundary};

  led_pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_tb (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_duty     (r_duty),
    .o_tick     (w_tick),
    .o_boundary (w_boundary),
    .o_pwm_on   (w_pwm_on)
  );

  // duty register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_duty <= DUTY_RST;
    else if (w_wr && address == ADDR_DUTY)
      r_duty <= writedata[7:0];
  end

`ifdef LED_PWM_DRIVER_BLINK_EN
  logic [9:0]   r_mask;
  logic [15:0]  r_hp;
  logic [15:0]  r_bcnt;
  logic [15:0]  w_bcnt_nxt;
  blink_state_e r_state;
  blink_state_e w_state_nxt;
  logic         w_wr_half;

  assign w_wr_half  = w_wr && (address == ADDR_HALF);
  assign w_mask     = r_mask;
  assign w_hp       = r_hp;
  assign w_blink_on = (r_state == BLINK_ON);

  // blink configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_hp   <= HALF_RST;
    end else begin
      if (w_wr && address == ADDR_MASK)
        r_mask <= writedata[9:0];
      if (w_wr_half)
        r_hp <= writedata[15:0];
    end
  end

  // blink state and period counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= BLINK_ON;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // blink next state; a half_period write restarts the cycle
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    if (w_wr_half) begin
      w_state_nxt = BLINK_ON;
      w_bcnt_nxt  = '0;
    end else if (w_boundary) begin
      if (r_hp == 16'd0) begin
        w_state_nxt = BLINK_ON;
      end else if (r_bcnt == r_hp - 16'd1) begin
        w_state_nxt = (r_state == BLINK_ON) ?
                      BLINK_OFF : BLINK_ON;
        w_bcnt_nxt  = '0;
      end else begin
        w_bcnt_nxt  = r_bcnt + 16'd1;
      end
    end
  end
`else
  assign w_mask     = '0;
  assign w_hp       = '0;
  assign w_blink_on = 1'b1;
`endif

  // input capture and gated LED drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led_q   <= '0;
      r_led_out <= '0;
    end else begin
      r_led_q   <= led_in;
      r_led_out <= r_led_q & {10{w_pwm_on}} &
                   (~w_mask | {10{w_blink_on}});
    end
  end

  // register readback, combinational from address
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DUTY: readdata = {24'b0, r_duty};
      ADDR_MASK: readdata = zext10(w_mask);
      ADDR_HALF: readdata = {16'b0, w_hp};
      ADDR_LED:  readdata = zext10(r_led_out);
      default:   readdata = '0;
    endcase
  end

endmodule
